ibus_responder: RTL and testbench

IBUS_RESPONDER -- requirements
Module: ibus_responder

---
 rtl/ibus_pkg.sv | 17 +
 rtl/ibus_responder.sv | 149 ++++++++++++++
 tb/tb_ibus_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_pkg.sv
// Instruction-bus payload types shared by the responder and its users.
//   ibus_req_t  : valid, 64-bit byte address
//   ibus_resp_t : addr_ok, data_ok, 32-bit instruction word
package ibus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/ibus_responder.sv
// Instruction-bus responder backed by a loadable word array, with a
// programmable request-to-data latency.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ireq                request (valid, addr), held stable until data_ok
//   iresp               response (addr_ok, data_ok, data); data is 0 unless data_ok
//   ld_en/ld_idx/ld_data array write port, usable in any state
//   err                 high with data_ok for an out-of-range or misaligned address
//   resp_cnt            count of completed responses (wraps)
module ibus_responder
  import ibus_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 10,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  ibus_req_t     ireq,
  output ibus_resp_t    iresp,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data,
  output logic          err,
  output logic [31:0]   resp_cnt
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [63:0] SPAN     = 64'(1) << (AW + 2);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   resp_cnt_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept_c;
  logic          addr_ok_c;
  logic          data_ok_c;
  logic [63:0]   rd_addr_c;
  logic [63:0]   off_c;
  logic          bad_c;
  logic [AW-1:0] rd_idx_c;

  // Zero-latency requests are served straight from the bus address.
  always_comb begin
    rd_addr_c = (state_q == IDLE) ? ireq.addr : addr_q;
    off_c     = rd_addr_c - BASE;
    bad_c     = (rd_addr_c < BASE) || (off_c >= SPAN) || (rd_addr_c[1:0] != 2'b00);
    rd_idx_c  = off_c[AW+1:2];
  end

  // Next-state logic; any acceptance (fresh or redirect) shares one path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    accept_c  = 1'b0;
    addr_ok_c = 1'b0;
    data_ok_c = 1'b0;

    case (state_q)
      IDLE: accept_c = ireq.valid;
      WAIT: begin
        if (!ireq.valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (ireq.addr != addr_q) begin
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (!ireq.valid) begin
          state_d = IDLE;
        end else if (ireq.addr != addr_q) begin
          accept_c = 1'b1;
        end else begin
          data_ok_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      addr_ok_c = 1'b1;
      addr_d    = ireq.addr;
      if (LATENCY == 0) begin
        data_ok_c = 1'b1;
        state_d   = IDLE;
      end else if (LATENCY == 1) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  // Response drive; reset masks even a same-cycle zero-latency response.
  always_comb begin
    iresp = '0;
    err   = 1'b0;
    if (!reset) begin
      iresp.addr_ok = addr_ok_c;
      if (data_ok_c) begin
        iresp.data_ok = 1'b1;
        iresp.data    = bad_c ? NOP : mem_q[rd_idx_c];
        err           = bad_c;
      end
    end
  end

  // State, latched address, latency counter and response counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 64'd0;
      resp_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (data_ok_c) begin
        resp_cnt_q <= resp_cnt_q + 32'd1;
      end
    end
  end

  // Instruction array; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

  assign resp_cnt = resp_cnt_q;

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: three instances (LATENCY 2, 0, 3) share all
// inputs; a vector table exercises the LATENCY=2 instance, and short
// hand-written sequences cover reset-in-WAIT, zero latency and redirect.
module tb_ibus_responder;
  import ibus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  ibus_req_t   req   = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = 10'd0;
  logic [31:0] ld_data = 32'd0;

  ibus_resp_t  resp2, resp0, resp3;
  logic        err2, err0, err3;
  logic [31:0] cnt2, cnt0, cnt3;

  int n_vec  = 0;
  int n_fail = 0;

  ibus_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp2), .ld_en(ld_en),
    .ld_idx(ld_idx), .ld_data(ld_data), .err(err2), .resp_cnt(cnt2));
  ibus_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp0), .ld_en(ld_en),
    .ld_idx(ld_idx), .ld_data(ld_data), .err(err0), .resp_cnt(cnt0));
  ibus_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .ireq(req), .iresp(resp3), .ld_en(ld_en),
    .ld_idx(ld_idx), .ld_data(ld_data), .err(err3), .resp_cnt(cnt3));

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [63:0] a, logic le, logic [9:0] li,
                              logic [31:0] ld, logic aok, logic dok,
                              logic [31:0] d, logic e, logic [31:0] c);
    vec_t x;
    x.valid = v;  x.addr = a;  x.ld_en = le;  x.ld_idx = li;  x.ld_data = ld;
    x.addr_ok = aok;  x.data_ok = dok;  x.data = d;  x.err = e;  x.cnt = c;
    return x;
  endfunction

  function automatic vec_t rq(logic v, logic [63:0] a, logic aok, logic dok,
                              logic [31:0] d, logic e, logic [31:0] c);
    return mk(v, a, 1'b0, 10'd0, 32'd0, aok, dok, d, e, c);
  endfunction

  function automatic vec_t ld(logic [9:0] li, logic [31:0] dd, logic [31:0] c);
    return mk(1'b0, 64'd0, 1'b1, li, dd, 1'b0, 1'b0, 32'd0, 1'b0, c);
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic cyc(input logic r, input logic v, input logic [63:0] a,
                     input logic le, input logic [9:0] li, input logic [31:0] dd);
    @(negedge clk);
    reset = r;  req.valid = v;  req.addr = a;
    ld_en = le;  ld_idx = li;  ld_data = dd;
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  localparam logic [63:0] A0 = 64'h8000_0000;

  initial begin
    logic [66:0] act, exv;

    cyc(1'b1, 1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
    cyc(1'b1, 1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
    chk("reset_resp2", 64'(resp2), 64'd0);
    chk("reset_err2", 64'(err2), 64'd0);
    chk("reset_cnt2", 64'(cnt2), 64'd0);
    chk("reset_cnt3", 64'(cnt3), 64'd0);

    // Array loads.
    vq.push_back(ld(10'd0,    32'h0010_0093, 32'd0));
    vq.push_back(ld(10'd1,    32'hDEAD_BEEF, 32'd0));
    vq.push_back(ld(10'd2,    32'h2222_2222, 32'd0));
    vq.push_back(ld(10'd5,    32'h5555_5555, 32'd0));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0));
    // Basic request: data_ok two cycles after acceptance.
    vq.push_back(rq(1'b1, A0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0));
    vq.push_back(rq(1'b1, A0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0));
    vq.push_back(rq(1'b1, A0, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'd0));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1));
    // Back-to-back at the same address.
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd1));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd1));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd2));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd3));
    // Misaligned address.
    vq.push_back(rq(1'b1, A0 + 64'd2, 1'b1, 1'b0, 32'd0, 1'b0, 32'd3));
    vq.push_back(rq(1'b1, A0 + 64'd2, 1'b0, 1'b0, 32'd0, 1'b0, 32'd3));
    vq.push_back(rq(1'b1, A0 + 64'd2, 1'b0, 1'b1, 32'h13, 1'b1, 32'd3));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd4));
    // Below base.
    vq.push_back(rq(1'b1, 64'h7FFF_FFFC, 1'b1, 1'b0, 32'd0, 1'b0, 32'd4));
    vq.push_back(rq(1'b1, 64'h7FFF_FFFC, 1'b0, 1'b0, 32'd0, 1'b0, 32'd4));
    vq.push_back(rq(1'b1, 64'h7FFF_FFFC, 1'b0, 1'b1, 32'h13, 1'b1, 32'd4));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd5));
    // One word past the top of the array.
    vq.push_back(rq(1'b1, 64'h8000_1000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd5));
    vq.push_back(rq(1'b1, 64'h8000_1000, 1'b0, 1'b0, 32'd0, 1'b0, 32'd5));
    vq.push_back(rq(1'b1, 64'h8000_1000, 1'b0, 1'b1, 32'h13, 1'b1, 32'd5));
    // Last valid word.
    vq.push_back(ld(10'd1023, 32'hFFFF_0000, 32'd6));
    vq.push_back(rq(1'b1, 64'h8000_0FFC, 1'b1, 1'b0, 32'd0, 1'b0, 32'd6));
    vq.push_back(rq(1'b1, 64'h8000_0FFC, 1'b0, 1'b0, 32'd0, 1'b0, 32'd6));
    vq.push_back(rq(1'b1, 64'h8000_0FFC, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 32'd6));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7));
    // Abort: valid drops in WAIT.
    vq.push_back(rq(1'b1, A0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd7));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7));
    // Same-cycle read and write of idx5: old word, then new word on repeat.
    vq.push_back(rq(1'b1, A0 + 64'h14, 1'b1, 1'b0, 32'd0, 1'b0, 32'd7));
    vq.push_back(rq(1'b1, A0 + 64'h14, 1'b0, 1'b0, 32'd0, 1'b0, 32'd7));
    vq.push_back(mk(1'b1, A0 + 64'h14, 1'b1, 10'd5, 32'hAAAA_5555,
                    1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'd7));
    vq.push_back(rq(1'b1, A0 + 64'h14, 1'b1, 1'b0, 32'd0, 1'b0, 32'd8));
    vq.push_back(rq(1'b1, A0 + 64'h14, 1'b0, 1'b0, 32'd0, 1'b0, 32'd8));
    vq.push_back(rq(1'b1, A0 + 64'h14, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0, 32'd8));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd9));
    // Redirect in WAIT restarts the full latency.
    vq.push_back(rq(1'b1, A0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd9));
    vq.push_back(rq(1'b1, A0 + 64'd8, 1'b1, 1'b0, 32'd0, 1'b0, 32'd9));
    vq.push_back(rq(1'b1, A0 + 64'd8, 1'b0, 1'b0, 32'd0, 1'b0, 32'd9));
    vq.push_back(rq(1'b1, A0 + 64'd8, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'd9));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd10));
    // Redirect in RESP suppresses the stale response.
    vq.push_back(rq(1'b1, A0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd10));
    vq.push_back(rq(1'b1, A0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd10));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b1, 1'b0, 32'd0, 1'b0, 32'd10));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd10));
    vq.push_back(rq(1'b1, A0 + 64'd4, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd10));
    vq.push_back(rq(1'b0, 64'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd11));

    foreach (vq[i]) begin
      cyc(1'b0, vq[i].valid, vq[i].addr, vq[i].ld_en, vq[i].ld_idx, vq[i].ld_data);
      act = {resp2.addr_ok, resp2.data_ok, resp2.data, err2, cnt2};
      exv = {vq[i].addr_ok, vq[i].data_ok, vq[i].data, vq[i].err, vq[i].cnt};
      n_vec++;
      if (act !== exv) begin
        n_fail++;
        $display("FAIL vec%0d: got aok=%b dok=%b data=%h err=%b cnt=%0d expected aok=%b dok=%b data=%h err=%b cnt=%0d",
                 i, act[66], act[65], act[64:33], act[32], act[31:0],
                 exv[66], exv[65], exv[64:33], exv[32], exv[31:0]);
      end
    end

    // Reset while the LATENCY=2 instance is in WAIT.
    cyc(1'b0, 1'b1, A0, 1'b0, 10'd0, 32'd0);
    chk("rstw_accept", 64'(resp2.addr_ok), 64'd1);
    cyc(1'b1, 1'b1, A0, 1'b0, 10'd0, 32'd0);
    chk("rstw_resp2", 64'(resp2), 64'd0);
    chk("rstw_err2", 64'(err2), 64'd0);
    chk("rstw_resp0_masked", 64'(resp0), 64'd0);
    chk("rstw_err0_masked", 64'(err0), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
      chk($sformatf("rstw_quiet%0d", k), 64'(resp2), 64'd0);
    end
    chk("rstw_cnt2", 64'(cnt2), 64'd0);
    chk("rstw_cnt0", 64'(cnt0), 64'd0);

    // Zero latency: same-cycle response, including an error response.
    cyc(1'b0, 1'b1, A0 + 64'd4, 1'b0, 10'd0, 32'd0);
    chk("l0_resp", 64'(resp0), {30'd0, 1'b1, 1'b1, 32'hDEAD_BEEF});
    chk("l0_err", 64'(err0), 64'd0);
    cyc(1'b0, 1'b1, A0 + 64'd1, 1'b0, 10'd0, 32'd0);
    chk("l0_bad_resp", 64'(resp0), {30'd0, 1'b1, 1'b1, 32'h13});
    chk("l0_bad_err", 64'(err0), 64'd1);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
    chk("l0_idle", 64'(resp0), 64'd0);
    chk("l0_cnt", 64'(cnt0), 64'd2);
    chk("l3_cnt_pre", 64'(cnt3), 64'd0);

    // LATENCY=3 with a redirect one cycle after acceptance.
    cyc(1'b0, 1'b1, A0, 1'b0, 10'd0, 32'd0);
    chk("l3_c0", 64'(resp3), {30'd0, 1'b1, 1'b0, 32'd0});
    cyc(1'b0, 1'b1, A0 + 64'd8, 1'b0, 10'd0, 32'd0);
    chk("l3_c1", 64'(resp3), {30'd0, 1'b1, 1'b0, 32'd0});
    cyc(1'b0, 1'b1, A0 + 64'd8, 1'b0, 10'd0, 32'd0);
    chk("l3_c2", 64'(resp3), 64'd0);
    cyc(1'b0, 1'b1, A0 + 64'd8, 1'b0, 10'd0, 32'd0);
    chk("l3_c3", 64'(resp3), 64'd0);
    cyc(1'b0, 1'b1, A0 + 64'd8, 1'b0, 10'd0, 32'd0);
    chk("l3_c4", 64'(resp3), {30'd0, 1'b0, 1'b1, 32'h2222_2222});
    chk("l3_c4_err", 64'(err3), 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 1'b0, 10'd0, 32'd0);
    chk("l3_c5", 64'(resp3), 64'd0);
    chk("l3_cnt", 64'(cnt3), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
